// File: rtl/class_argmax_reader_pkg.sv
// Shared definitions for the class argmax output stage: FP32 field
// positions, default dimensions (NUM_IMG / NUM_CLASS) and the reader FSM
// encoding.
package class_argmax_reader_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;
   localparam logic [7:0] EXP_ALL1 = 8'hFF;

   localparam int DEF_NUM_IMG   = 4;
   localparam int DEF_NUM_CLASS = 1000;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_RESULT  = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
   function automatic logic fp32_is_nan(input logic [31:0] v);
      return (v[EXP_MSB:EXP_LSB] == EXP_ALL1) && (v[MAN_MSB:0] != '0);
   endfunction

endpackage

// File: rtl/class_argmax_reader_if.sv
// Bus between the vip_top output FIFO / result consumer and the argmax
// reader. Optional nan_flag signal exists only with ARGMAX_NAN_FLAG_EN.
interface class_argmax_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CLASS  = class_argmax_reader_pkg::DEF_NUM_CLASS,
   parameter int NUM_IMG    = class_argmax_reader_pkg::DEF_NUM_IMG
) ();
   logic [DATA_WIDTH:0]              fifo_data;
   logic                             fifo_empty;
   logic                             fifo_rdreq;
   logic                             result_valid;
   logic                             result_ready;
   logic [$clog2(NUM_CLASS)-1:0]     result_class;
   logic [DATA_WIDTH-1:0]            result_score;
   logic [$clog2(NUM_IMG+1)-1:0]     result_img;
   logic                             done;
`ifdef ARGMAX_NAN_FLAG_EN
   logic                             nan_flag;
`endif

   // Reader side.
   modport master (
      input  fifo_data, fifo_empty, result_ready,
      output fifo_rdreq, result_valid, result_class, result_score, result_img, done
`ifdef ARGMAX_NAN_FLAG_EN
      , output nan_flag
`endif
   );

   // FIFO / consumer side.
   modport slave (
      output fifo_data, fifo_empty, result_ready,
      input  fifo_rdreq, result_valid, result_class, result_score, result_img, done
`ifdef ARGMAX_NAN_FLAG_EN
      , input nan_flag
`endif
   );
endinterface

// File: rtl/class_argmax_reader_fp32_gt.sv
// Combinational FP32 strict greater-than (a > b). +0 and -0 are equal;
// NaNs fall through the sign/magnitude rules with no special handling.
module fp32_gt
   import class_argmax_reader_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        gt_o
);
   logic [SIGN_BIT-1:0] mag_a, mag_b;
   logic                both_zero;

   assign mag_a     = a_i[SIGN_BIT-1:0];
   assign mag_b     = b_i[SIGN_BIT-1:0];
   assign both_zero = (mag_a == '0) && (mag_b == '0);

   // Sign first, then magnitude (reversed ordering for negatives).
   always_comb begin
      gt_o = 1'b0;
      if (a_i[SIGN_BIT] != b_i[SIGN_BIT])
         gt_o = !a_i[SIGN_BIT] && !both_zero;
      else if (!a_i[SIGN_BIT])
         gt_o = mag_a > mag_b;
      else
         gt_o = mag_a < mag_b;
   end
endmodule

// File: rtl/class_argmax_reader.sv
// Output stage after vip_top: pops {image_class, score} words, keeps the
// running argmax over NUM_CLASS class scores per image and hands one result
// per image over valid/ready; done goes sticky after NUM_IMG results.
// Optional feature macro: ARGMAX_NAN_FLAG_EN (NaN scores never win, and a
// per-image nan_flag is presented with the result).
module class_argmax_reader
   import class_argmax_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CLASS  = DEF_NUM_CLASS,
   parameter int NUM_IMG    = DEF_NUM_IMG
) (
   input  logic                  clock,
   input  logic                  reset,
   class_argmax_reader_if.master bus
);
   localparam int CNT_W = $clog2(NUM_CLASS + 1);
   localparam int CLS_W = $clog2(NUM_CLASS);
   localparam int IMG_W = $clog2(NUM_IMG + 1);
   localparam logic [CNT_W:0]   NC_EXT   = (CNT_W+1)'(NUM_CLASS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASS - 1);
   localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMG - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cls_cnt_q, cls_cnt_d;
   logic [IMG_W-1:0]        img_cnt_q, img_cnt_d;
   logic                    rd_pend_q;
   logic [DATA_WIDTH-1:0]   best_q, best_d;
   logic [CLS_W-1:0]        best_idx_q, best_idx_d;
   logic [CLS_W-1:0]        res_class_q, res_class_d;
   logic [DATA_WIDTH-1:0]   res_score_q, res_score_d;
   logic                    done_q, done_d;
`ifdef ARGMAX_NAN_FLAG_EN
   logic                    have_best_q, have_best_d;
   logic                    nan_seen_q, nan_seen_d;
   logic                    res_nan_q, res_nan_d;
   logic                    score_nan;
`endif

   logic [DATA_WIDTH-1:0]   score;
   logic                    score_gt;
   logic                    cls_word;
   logic [CNT_W:0]          inflight;

   assign score    = bus.fifo_data[DATA_WIDTH-1:0];
   assign cls_word = rd_pend_q && bus.fifo_data[DATA_WIDTH];
   assign inflight = {1'b0, cls_cnt_q} + {{CNT_W{1'b0}}, rd_pend_q};
`ifdef ARGMAX_NAN_FLAG_EN
   assign score_nan = fp32_is_nan(score);
`endif

   fp32_gt u_gt (
      .a_i  (score),
      .b_i  (best_q),
      .gt_o (score_gt)
   );

   // Pop only while collecting and while the words already counted plus the
   // one in flight cannot exceed this image's class words; reset gates it
   // so every output is 0 the moment reset rises.
   assign bus.fifo_rdreq   = !reset && (state_q == ST_COLLECT) && !bus.fifo_empty
                             && (inflight < NC_EXT);
   assign bus.result_valid = (state_q == ST_RESULT);
   assign bus.result_class = res_class_q;
   assign bus.result_score = res_score_q;
   assign bus.result_img   = img_cnt_q;
   assign bus.done         = done_q;
`ifdef ARGMAX_NAN_FLAG_EN
   assign bus.nan_flag     = res_nan_q;
`endif

   // Next state: running argmax while collecting, result hand-off, done.
   always_comb begin
      state_d     = state_q;
      cls_cnt_d   = cls_cnt_q;
      img_cnt_d   = img_cnt_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      res_class_d = res_class_q;
      res_score_d = res_score_q;
      done_d      = done_q;
`ifdef ARGMAX_NAN_FLAG_EN
      have_best_d = have_best_q;
      nan_seen_d  = nan_seen_q;
      res_nan_d   = res_nan_q;
`endif
      case (state_q)
         ST_COLLECT: begin
            if (cls_word) begin
`ifdef ARGMAX_NAN_FLAG_EN
               // A NaN never becomes the best; have_best tracks whether any
               // real score has been seen yet in this image.
               if (cls_cnt_q == '0) begin
                  best_d      = score_nan ? '0 : score;
                  best_idx_d  = '0;
                  have_best_d = !score_nan;
                  nan_seen_d  = score_nan;
               end else begin
                  nan_seen_d = nan_seen_q || score_nan;
                  if (!score_nan && (!have_best_q || score_gt)) begin
                     best_d      = score;
                     best_idx_d  = cls_cnt_q[CLS_W-1:0];
                     have_best_d = 1'b1;
                  end
               end
`else
               if ((cls_cnt_q == '0) || score_gt) begin
                  best_d     = score;
                  best_idx_d = cls_cnt_q[CLS_W-1:0];
               end
`endif
               cls_cnt_d = cls_cnt_q + CNT_W'(1);
               if (cls_cnt_q == LAST_CNT) begin
                  res_class_d = best_idx_d;
                  res_score_d = best_d;
`ifdef ARGMAX_NAN_FLAG_EN
                  res_nan_d   = nan_seen_d;
`endif
                  state_d     = ST_RESULT;
               end
            end
         end
         ST_RESULT: begin
            if (bus.result_ready) begin
               cls_cnt_d = '0;
               img_cnt_d = img_cnt_q + IMG_W'(1);
`ifdef ARGMAX_NAN_FLAG_EN
               res_nan_d = 1'b0;
`endif
               if (img_cnt_q == IMG_LAST) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         default: state_d = state_q;
      endcase
   end

   // State, counters and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_COLLECT;
         cls_cnt_q   <= '0;
         img_cnt_q   <= '0;
         rd_pend_q   <= 1'b0;
         best_q      <= '0;
         best_idx_q  <= '0;
         res_class_q <= '0;
         res_score_q <= '0;
         done_q      <= 1'b0;
`ifdef ARGMAX_NAN_FLAG_EN
         have_best_q <= 1'b0;
         nan_seen_q  <= 1'b0;
         res_nan_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cls_cnt_q   <= cls_cnt_d;
         img_cnt_q   <= img_cnt_d;
         rd_pend_q   <= bus.fifo_rdreq;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         res_class_q <= res_class_d;
         res_score_q <= res_score_d;
         done_q      <= done_d;
`ifdef ARGMAX_NAN_FLAG_EN
         have_best_q <= have_best_d;
         nan_seen_q  <= nan_seen_d;
         res_nan_q   <= res_nan_d;
`endif
      end
   end
endmodule

// File: tb/tb_class_argmax_reader.sv
// Bench for class_argmax_reader with NUM_CLASS=4, NUM_IMG=2. A queue-based
// FIFO model feeds the DUT; a real-number argmax model predicts each result.
module tb_class_argmax_reader;
   localparam int DW = 32;
   localparam int NC = 4;
   localparam int NI = 2;

   typedef struct { logic [32:0] w; int img; } fent_t;
   typedef struct { int cls; logic [31:0] sc; int img; bit nan; } exp_t;

   logic  clock;
   logic  reset;
   fent_t fq[$];
   exp_t  exp_q[$];
   int    pops_img[4];
   int    cyc, last_pop_cyc;
   bit    rand_stall;
   int    n_vec, n_err;
   int    acc_cnt;
   int    img_idx;

   class_argmax_reader_if #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .NUM_IMG(NI)) bus ();

   class_argmax_reader #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .NUM_IMG(NI)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic real fp2r(input logic [31:0] v);
      int  e = int'(v[30:23]);
      real m = real'(v[22:0]);
      real r;
      if (e == 255)    r = 1.0e300;
      else if (e == 0) r = m * (2.0 ** (-149));
      else             r = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
      return v[31] ? -r : r;
   endfunction

   // Argmax by value: lowest index wins ties, NaNs skipped when flagged.
   task automatic model(input logic [31:0] s[4], output int idx, output logic [31:0] sc,
                        output bit nan);
      real best;
      idx = -1; nan = 1'b0; best = 0.0;
      for (int i = 0; i < NC; i++) begin
         nan |= is_nan(s[i]);
`ifdef ARGMAX_NAN_FLAG_EN
         if (is_nan(s[i])) continue;
`endif
         if (idx < 0 || fp2r(s[i]) > best) begin
            best = fp2r(s[i]);
            idx  = i;
         end
      end
      if (idx < 0) begin idx = 0; sc = 32'd0; end
      else sc = s[idx];
   endtask

   // FIFO model: normal (non show-ahead) read, data the cycle after rdreq.
   initial begin
      bit stall;
      cyc = 0; last_pop_cyc = 0;
      bus.fifo_data  = '0;
      bus.fifo_empty = 1'b1;
      forever begin
         @(posedge clock);
         cyc++;
         if (reset) begin
            foreach (pops_img[i]) pops_img[i] = 0;
            bus.fifo_empty <= 1'b1;
            continue;
         end
         if (bus.fifo_rdreq) begin
            if (fq.size() == 0) chk("pop_on_empty_queue", 1, 0);
            else begin
               bus.fifo_data <= fq[0].w;
               if (fq[0].w[32]) begin
                  pops_img[fq[0].img]++;
                  last_pop_cyc = cyc;
               end
               void'(fq.pop_front());
            end
         end
         stall = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.fifo_empty <= (fq.size() == 0) || stall;
      end
   end

   // Compare process: every cycle, against the expected-result queue.
   initial begin
      bit          seen;
      logic [31:0] h_sc;
      int          h_cls, h_img;
      seen = 0; acc_cnt = 0; h_sc = '0; h_cls = 0; h_img = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            chk("rst_rdreq", bus.fifo_rdreq, 0);
            chk("rst_valid", bus.result_valid, 0);
            chk("rst_done",  bus.done, 0);
            chk("rst_class", bus.result_class, 0);
            chk("rst_score", bus.result_score, 0);
            chk("rst_img",   bus.result_img, 0);
            seen = 0; acc_cnt = 0;
            continue;
         end
         chk("done", bus.done, acc_cnt >= NI);
         chk("rdreq_when_empty", bus.fifo_rdreq & bus.fifo_empty, 0);
         if (bus.result_valid) begin
            chk("rdreq_while_valid", bus.fifo_rdreq, 0);
            if (!seen) begin
               if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
               else begin
                  chk("class", bus.result_class, exp_q[0].cls);
                  chk("score", bus.result_score, exp_q[0].sc);
                  chk("img",   bus.result_img, exp_q[0].img);
`ifdef ARGMAX_NAN_FLAG_EN
                  chk("nan_flag", bus.nan_flag, exp_q[0].nan);
`endif
                  chk("latency_pop_to_valid", cyc - last_pop_cyc, 1);
                  chk("class_words_consumed", pops_img[exp_q[0].img], NC);
                  if (exp_q[0].img + 1 < 4)
                     chk("next_image_overread", pops_img[exp_q[0].img + 1], 0);
               end
               h_cls = int'(bus.result_class);
               h_sc  = bus.result_score;
               h_img = int'(bus.result_img);
               seen  = 1;
            end else begin
               chk("stable_class", bus.result_class, h_cls);
               chk("stable_score", bus.result_score, h_sc);
               chk("stable_img",   bus.result_img, h_img);
            end
            if (bus.result_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               acc_cnt++;
               seen = 0;
            end
         end else if (seen) begin
            chk("valid_dropped", bus.result_valid, 1);
            seen = 0;
         end
      end
   end

   // Queue one image; optionally interleave non-class words that would win.
   task automatic push_img(input logic [31:0] s[4], input bit mix, input int pin_cls,
                           input logic [31:0] pin_sc);
      exp_t e;
      model(s, e.cls, e.sc, e.nan);
      if (pin_cls >= 0) begin
         chk("model_class_pin", e.cls, pin_cls);
         chk("model_score_pin", e.sc, pin_sc);
      end
      e.img = img_idx;
      exp_q.push_back(e);
      for (int i = 0; i < NC; i++) begin
         if (mix) fq.push_back('{{1'b0, 32'h7F7F0000 | 32'($urandom_range(0, 65535))}, img_idx});
         fq.push_back('{{1'b1, s[i]}, img_idx});
      end
      if (mix) fq.push_back('{{1'b0, 32'h7F000001}, img_idx});
      img_idx++;
   endtask

   task automatic accept(input int hold);
      int t = 0;
      while (!bus.result_valid && t < 300) begin @(posedge clock); #1; t++; end
      chk("result_wait", bus.result_valid, 1);
      repeat (hold) begin @(posedge clock); #1; end
      bus.result_ready = 1'b1;
      @(posedge clock); #1;
      bus.result_ready = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!bus.done && t < 50) begin @(posedge clock); #1; t++; end
      chk("done_wait", bus.done, 1);
   endtask

   task automatic flush_model();
      fq.delete();
      exp_q.delete();
      img_idx = 0;
   endtask

   task automatic do_reset();
      @(posedge clock); #2;
      reset = 1'b1;
      flush_model();
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
   endtask

   initial begin
      logic [31:0] t1[4], t2[4], tz[4];
      int t;
      t1 = '{32'h3F800000, 32'h40600000, 32'hC0000000, 32'h3F000000};
      t2 = '{32'hBF800000, 32'hBF000000, 32'hC0400000, 32'hBF000000};
      tz = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'h80000000};
      n_vec = 0; n_err = 0; img_idx = 0; rand_stall = 0;
      bus.result_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Back-to-back images, both queued up front, immediate accept.
      @(posedge clock); #1;
      push_img(t1, 0, 1, 32'h40600000);
      push_img(t2, 0, 1, 32'hBF000000);
      accept(0);
      accept(0);
      wait_done();

      // Interleaved non-class words, random empty, held-off accept.
      do_reset();
      rand_stall = 1;
      push_img(t1, 1, 1, 32'h40600000);
      push_img(t2, 1, 1, 32'hBF000000);
      accept(0);
      accept(10);
      wait_done();
      rand_stall = 0;

      // Reset mid-image after two class words, then fresh images.
      do_reset();
      push_img(t1, 0, -1, 32'h0);
      t = 0;
      while (pops_img[0] < 2 && t < 50) begin @(posedge clock); #1; t++; end
      chk("midreset_pops_reached", pops_img[0] >= 2, 1);
      reset = 1'b1;
      #1;
      chk("midreset_rdreq", bus.fifo_rdreq, 0);
      chk("midreset_valid", bus.result_valid, 0);
      chk("midreset_done",  bus.done, 0);
      chk("midreset_class", bus.result_class, 0);
      chk("midreset_score", bus.result_score, 0);
      chk("midreset_img",   bus.result_img, 0);
      flush_model();
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      @(posedge clock); #1;
      push_img(t2, 0, 1, 32'hBF000000);
      push_img(tz, 0, 0, 32'h80000000);
      accept(0);
      accept(3);
      wait_done();

`ifdef ARGMAX_NAN_FLAG_EN
      begin
         logic [31:0] tn[4], tp[4];
         tn = '{32'h7FC00000, 32'h40000000, 32'h3F800000, 32'h00000000};
         tp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
         do_reset();
         push_img(tn, 0, 1, 32'h40000000);
         chk("model_nan_pin", exp_q[0].nan, 1);
         push_img(tp, 0, 3, 32'h40800000);
         accept(2);
         accept(0);
         wait_done();
      end
`endif

      repeat (3) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
